brick_wall: RTL and testbench

- Breakout-style brick field that answers the collision probes a ball block makes during scan-out.
- Combinationally reports, for the current hcount/vcount, whether the pixel is a live brick. The top level ORs this into the pixel "empty" signal seen by the ball.
- On each ball move strobe, erases every live brick touched by the ball's four edge probe points. It also keeps score and flags level-clear.

---
 rtl/brick_wall_if.sv | 25 ++
 rtl/brick_wall.sv | 114 +++++++++++
 tb/tb_brick_wall.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/brick_wall_if.sv
// Scan, ball and status signals shared between the brick field and its neighbours.
// The master side drives scan position, ball position and strobes. The slave side returns pixel and score status.
interface brick_wall_if;
  logic       pixpulse;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [9:0] xloc;
  logic [9:0] yloc;
  logic       move;
  logic       reload;
  logic       draw_brick;
  logic       hit;
  logic [7:0] score;
  logic       cleared;

  modport master (
    output pixpulse, hcount, vcount, xloc, yloc, move, reload,
    input  draw_brick, hit, score, cleared
  );

  modport slave (
    input  pixpulse, hcount, vcount, xloc, yloc, move, reload,
    output draw_brick, hit, score, cleared
  );
endinterface

// File: rtl/brick_wall.sv
// Breakout brick field. draw_brick is combinational from hcount/vcount.
// Each ball move runs four one-clk probes that erase any live brick they touch; there is no backpressure.
module brick_wall #(
  parameter int COLS    = 20,
  parameter int ROWS    = 6,
  parameter int BRICK_W = 32,
  parameter int BRICK_H = 8,
  parameter int Y_TOP   = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  brick_wall_if.slave  bus
);
  localparam int NCELL  = ROWS * COLS;
  localparam int BW_LOG = $clog2(BRICK_W);
  localparam int BH_LOG = $clog2(BRICK_H);
  localparam int Y_END  = Y_TOP + ROWS * BRICK_H;
  localparam int CI     = $clog2(NCELL);
  localparam int CW     = $clog2(NCELL + 1);

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3} state_t;

  state_t           state, state_nxt;
  logic [NCELL-1:0] alive_map;
  logic [CW-1:0]    alive_cnt;
  logic [7:0]       score_q;
  logic             cleared_q;
  logic [9:0]       bx, by;
  logic [9:0]       px, py;
  logic             probe_hit;
  logic [CI-1:0]    probe_idx;

  function automatic logic [CI-1:0] cell_idx(input logic [9:0] x, input logic [9:0] y);
    logic [9:0] row;
    logic [9:0] col;
    row = (y - 10'(Y_TOP)) >> BH_LOG;
    col = x >> BW_LOG;
    return CI'(int'(row) * COLS + int'(col));
  endfunction

  // The last pixel column and row of every brick pitch form the mortar gap.
  function automatic logic is_solid(input logic [9:0] x, input logic [9:0] y,
                                    input logic [NCELL-1:0] map);
    logic in_field;
    logic gap;
    in_field = (x < 10'(COLS * BRICK_W)) && (y >= 10'(Y_TOP)) && (y < 10'(Y_END));
    gap      = (&x[BW_LOG-1:0]) || (&y[BH_LOG-1:0]);
    return in_field && !gap && map[cell_idx(x, y)];
  endfunction

  assign bus.draw_brick = is_solid(bus.hcount, bus.vcount, alive_map);
  assign bus.hit        = probe_hit;
  assign bus.score      = score_q;
  assign bus.cleared    = cleared_q;

  always_comb begin
    state_nxt = state;
    px        = bx;
    py        = by;
    unique case (state)
      IDLE: if (bus.pixpulse && bus.move) state_nxt = P0;
      P0: begin
        px        = bx - 10'd2;
        state_nxt = P1;
      end
      P1: begin
        px        = bx + 10'd2;
        state_nxt = P2;
      end
      P2: begin
        py        = by - 10'd2;
        state_nxt = P3;
      end
      P3: begin
        py        = by + 10'd2;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.reload) state_nxt = IDLE;
  end

  // Probes see the bitmap already updated by the previous probe, so a brick scores once.
  assign probe_hit = (state != IDLE) && !bus.reload && is_solid(px, py, alive_map);
  assign probe_idx = cell_idx(px, py);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alive_map <= '1;
      alive_cnt <= CW'(NCELL);
      score_q   <= 8'd0;
      cleared_q <= 1'b0;
      bx        <= 10'd0;
      by        <= 10'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.pixpulse && bus.move && !bus.reload) begin
        bx <= bus.xloc;
        by <= bus.yloc;
      end
      if (bus.reload) begin
        alive_map <= '1;
        alive_cnt <= CW'(NCELL);
        cleared_q <= 1'b0;
      end else if (probe_hit) begin
        alive_map[probe_idx] <= 1'b0;
        alive_cnt            <= alive_cnt - CW'(1);
        if (score_q != 8'hFF) score_q <= score_q + 8'd1;
        if (alive_cnt == CW'(1)) cleared_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_brick_wall.sv
// Scoreboard bench for brick_wall: a bitmap model predicts per-probe hits, cleared and score for every move.
`timescale 1ns/1ps
module tb_brick_wall;
  localparam int COLS = 20, ROWS = 6, BW = 32, BH = 8, YT = 48, NCELL = 120;

  typedef struct {
    logic [3:0] hits;
    logic [3:0] clrs;
    logic [7:0] score;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  bit mdl_map [ROWS][COLS];
  int mdl_alive;
  int mdl_score;
  bit mdl_clr;

  brick_wall_if bus();
  brick_wall dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic bit mdl_solid(input int x, input int y);
    if (x >= COLS * BW || y < YT || y >= YT + ROWS * BH) return 1'b0;
    if (x % BW == BW - 1 || y % BH == BH - 1) return 1'b0;
    return mdl_map[(y - YT) / BH][x / BW];
  endfunction

  task automatic mdl_refill(input bit zero_score);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mdl_map[r][c] = 1'b1;
    mdl_alive = NCELL;
    mdl_clr   = 1'b0;
    if (zero_score) mdl_score = 0;
  endtask

  initial begin
    bus.pixpulse = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.pixpulse = ~bus.pixpulse && (($time / 10) % 4 == 0);
    end
  end

  task automatic wait_pix(input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk);
      #2;
      got = bus.pixpulse;
    end
    chk_eq({tag, "_pixwait"}, 32'(got), 32'd1);
  endtask

  task automatic probe_at(input int x, input int y, input string tag, input logic exp);
    bus.hcount = 10'(x);
    bus.vcount = 10'(y);
    #0.1;
    chk_eq(tag, 32'(bus.draw_brick), 32'(exp));
  endtask

  task automatic scan_frame(input string tag);
    int errs = 0;
    for (int y = 0; y < 480; y++)
      for (int x = 0; x < 640; x++) begin
        bus.hcount = 10'(x);
        bus.vcount = 10'(y);
        #0.1;
        if (bus.draw_brick !== mdl_solid(x, y)) errs++;
      end
    chk_eq({tag, "_frame_errs"}, 32'(errs), 32'd0);
  endtask

  task automatic do_move(input logic [9:0] x, input logic [9:0] y, input string tag);
    exp_t       e;
    exp_t       got_e;
    logic [9:0] pxs [4];
    logic [9:0] pys [4];
    logic [3:0] hm, cm;
    pxs[0] = x - 10'd2; pys[0] = y;
    pxs[1] = x + 10'd2; pys[1] = y;
    pxs[2] = x;         pys[2] = y - 10'd2;
    pxs[3] = x;         pys[3] = y + 10'd2;
    e.hits = '0;
    e.clrs = '0;
    for (int i = 0; i < 4; i++) begin
      e.clrs[i] = mdl_clr;
      if (mdl_solid(int'(pxs[i]), int'(pys[i]))) begin
        mdl_map[(int'(pys[i]) - YT) / BH][int'(pxs[i]) / BW] = 1'b0;
        mdl_alive--;
        if (mdl_score < 255) mdl_score++;
        e.hits[i] = 1'b1;
        if (mdl_alive == 0) mdl_clr = 1'b1;
      end
    end
    e.score = 8'(mdl_score);
    sb_q.push_back(e);

    wait_pix(tag);
    bus.xloc = x;
    bus.yloc = y;
    bus.move = 1'b1;
    @(posedge clk);
    #2 bus.move = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hm[i] = bus.hit;
      cm[i] = bus.cleared;
    end
    @(negedge clk);
    got_e = sb_q.pop_front();
    chk_eq({tag, "_hits"}, 32'(hm), 32'(got_e.hits));
    chk_eq({tag, "_clr"}, 32'(cm), 32'(got_e.clrs));
    chk_eq({tag, "_score"}, 32'(bus.score), 32'(got_e.score));
  endtask

  // Start a move whose P0 lands on a gap and P1 on live brick r2 c3, then kill it during P1.
  task automatic abort_probe(input bit use_reset, input string tag);
    int hits_after = 0;
    wait_pix(tag);
    bus.xloc = 10'd97;
    bus.yloc = 10'd67;
    bus.move = 1'b1;
    @(posedge clk);
    #2 bus.move = 1'b0;
    @(negedge clk);
    chk_eq({tag, "_p0_hit"}, 32'(bus.hit), 32'd0);
    @(posedge clk);
    #1;
    if (use_reset) rst_n = 1'b0;
    else bus.reload = 1'b1;
    @(negedge clk);
    chk_eq({tag, "_p1_hit"}, 32'(bus.hit), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.reload = 1'b0;
    mdl_refill(use_reset);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.hit) hits_after++;
    end
    chk_eq({tag, "_hits_after"}, 32'(hits_after), 32'd0);
    probe_at(99, 67, {tag, "_p1_alive"}, 1'b1);
    probe_at(97, 65, {tag, "_p2_alive"}, 1'b1);
    chk_eq({tag, "_score"}, 32'(bus.score), 32'(mdl_score));
    chk_eq({tag, "_cleared"}, 32'(bus.cleared), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hcount = '0;
    bus.vcount = '0;
    bus.xloc   = '0;
    bus.yloc   = '0;
    bus.move   = 1'b0;
    bus.reload = 1'b0;
    mdl_refill(1'b1);
    repeat (3) @(negedge clk);
    chk_eq("rst_hit", 32'(bus.hit), 32'd0);
    chk_eq("rst_score", 32'(bus.score), 32'd0);
    chk_eq("rst_cleared", 32'(bus.cleared), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    probe_at(0, 48, "draw_0_48", 1'b1);
    probe_at(30, 54, "draw_30_54", 1'b1);
    probe_at(31, 48, "gap_col", 1'b0);
    probe_at(0, 55, "gap_row", 1'b0);
    probe_at(0, 47, "above_field", 1'b0);
    probe_at(0, 96, "below_field", 1'b0);
    scan_frame("reset");
    chk_eq("post_rst_score", 32'(bus.score), 32'd0);
    chk_eq("post_rst_cleared", 32'(bus.cleared), 32'd0);

    do_move(10'd40, 10'd58, "mv_40_58");
    probe_at(33, 57, "r1c1_gone", 1'b0);
    probe_at(0, 56, "r1c0_kept", 1'b1);

    do_move(10'd15, 10'd50, "mv_15_50");
    probe_at(5, 50, "r0c0_gone", 1'b0);

    do_move(10'd1, 10'd200, "mv_wrap");
    scan_frame("after_wrap");

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        do_move(10'(c * BW + 10), 10'(YT + r * BH + 3), $sformatf("erase_r%0dc%0d", r, c));
    chk_eq("all_score", 32'(bus.score), 32'd120);
    chk_eq("all_cleared", 32'(bus.cleared), 32'd1);
    scan_frame("empty");

    @(posedge clk);
    #1 bus.reload = 1'b1;
    @(posedge clk);
    #1 bus.reload = 1'b0;
    mdl_refill(1'b0);
    @(negedge clk);
    chk_eq("reload_cleared", 32'(bus.cleared), 32'd0);
    chk_eq("reload_score", 32'(bus.score), 32'd120);
    scan_frame("reload");

    abort_probe(1'b0, "abort_reload");
    abort_probe(1'b1, "abort_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
